// File: rtl/cpu_pkg.sv
// cpu_pkg: shared operation codes and state encoding for the execute-stage units
package cpu_pkg;
  localparam int ALUOpeLen = 4;
  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;
  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;
endpackage

// File: rtl/cpu_mul_div_step.sv
// cpu_mul_div_step: one radix-2 shift-add multiply or restoring divide iteration
module cpu_mul_div_step #(
  parameter int XLEN = 32
) (
  input  logic            div_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic [XLEN-1:0] m_i,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);
  logic [XLEN:0] sum, sh, diff;
  assign sum  = {1'b0, hi_i} + (lo_i[0] ? {1'b0, m_i} : '0);
  assign sh   = {hi_i, lo_i[XLEN-1]};
  assign diff = sh - {1'b0, m_i};
  assign hi_o = div_i ? (diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
  assign lo_o = div_i ? {lo_i[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo_i[XLEN-1:1]};
endmodule

// File: rtl/cpu_mul_div.sv
// cpu_mul_div: iterative RV32M multiply/divide unit with valid/ready handshake and kill
module cpu_mul_div
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kill,
  input  logic            inValid,
  output logic            inReady,
  input  logic [2:0]      MDOpe,
  input  logic [XLEN-1:0] MDIn1,
  input  logic [XLEN-1:0] MDIn2,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] MDOut,
  output logic            divZeroFlag,
  output logic            overflowFlag
);
  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};
  md_state_e         state_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   m_q, hi_q, lo_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_a_q, neg_ab_q;
  logic              s1, s2, na, nb, dz, ov;
  logic [XLEN-1:0]   mag1, mag2, spec_res, hi_d, lo_d, q_res, r_res, m_res, res_d;
  logic [2*XLEN-1:0] prod;
  assign s1       = (MDOpe == MD_MULH) | (MDOpe == MD_MULHSU) | (MDOpe == MD_DIV) | (MDOpe == MD_REM);
  assign s2       = (MDOpe == MD_MULH) | (MDOpe == MD_DIV) | (MDOpe == MD_REM);
  assign na       = s1 & MDIn1[XLEN-1];
  assign nb       = s2 & MDIn2[XLEN-1];
  assign mag1     = na ? -MDIn1 : MDIn1;
  assign mag2     = nb ? -MDIn2 : MDIn2;
  assign dz       = MDOpe[2] & (MDIn2 == '0);
  assign ov       = MDOpe[2] & ~MDOpe[0] & (MDIn1 == MIN) & (MDIn2 == '1);
  assign spec_res = dz ? (MDOpe[1] ? MDIn1 : '1) : (MDOpe[1] ? '0 : MIN);
  cpu_mul_div_step #(.XLEN(XLEN)) u_step (
    .div_i(op_q[2]),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .m_i  (m_q),
    .hi_o (hi_d),
    .lo_o (lo_d)
  );
  assign prod    = neg_ab_q ? -{hi_d, lo_d} : {hi_d, lo_d};
  assign m_res   = (op_q == MD_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign q_res   = neg_ab_q ? -lo_d : lo_d;
  assign r_res   = neg_a_q ? -hi_d : hi_d;
  assign res_d   = op_q[2] ? (op_q[1] ? r_res : q_res) : m_res;
  assign inReady = (state_q == MD_IDLE);
  // Handshake FSM, iteration counter and registered result/flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MD_IDLE;
      op_q         <= '0;
      m_q          <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      cnt_q        <= '0;
      neg_a_q      <= 1'b0;
      neg_ab_q     <= 1'b0;
      outValid     <= 1'b0;
      MDOut        <= '0;
      divZeroFlag  <= 1'b0;
      overflowFlag <= 1'b0;
    end else if (kill) begin
      state_q  <= MD_IDLE;
      outValid <= 1'b0;
    end else begin
      case (state_q)
        MD_IDLE: if (inValid) begin
          op_q     <= MDOpe;
          m_q      <= MDOpe[2] ? mag2 : mag1;
          hi_q     <= '0;
          lo_q     <= MDOpe[2] ? mag1 : mag2;
          cnt_q    <= '0;
          neg_a_q  <= na;
          neg_ab_q <= na ^ nb;
          if (dz | ov) begin
            MDOut        <= spec_res;
            divZeroFlag  <= dz;
            overflowFlag <= ov;
            outValid     <= 1'b1;
            state_q      <= MD_DONE;
          end else begin
            state_q <= MD_BUSY;
          end
        end
        MD_BUSY: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(XLEN - 1)) begin
            MDOut        <= res_d;
            divZeroFlag  <= 1'b0;
            overflowFlag <= 1'b0;
            outValid     <= 1'b1;
            state_q      <= MD_DONE;
          end
        end
        MD_DONE: if (outReady) begin
          outValid <= 1'b0;
          state_q  <= MD_IDLE;
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_mul_div.sv
// tb_cpu_mul_div: directed vectors, corner sequences and randomized model check
module tb_cpu_mul_div;
  import cpu_pkg::*;
  typedef logic [63:0] u64;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    logic        dz;
    logic        ov;
    int          lat;
  } vec_t;
  logic clk = 0, rst = 1, kill = 0;
  always #5 clk = ~clk;
  logic iv32 = 0, or32 = 0, ir32, ov32, dzf32, ovf32;
  logic [2:0] op32 = 0;
  logic [31:0] a32 = 0, b32 = 0, r32;
  logic iv8 = 0, or8 = 0, ir8, ov8, dzf8, ovf8;
  logic [2:0] op8 = 0;
  logic [7:0] a8 = 0, b8 = 0, r8;
  int n_tests = 0, n_fail = 0;
  cpu_mul_div #(.XLEN(32)) dut32 (
    .clk(clk), .rst(rst), .kill(kill), .inValid(iv32), .inReady(ir32), .MDOpe(op32),
    .MDIn1(a32), .MDIn2(b32), .outValid(ov32), .outReady(or32), .MDOut(r32),
    .divZeroFlag(dzf32), .overflowFlag(ovf32)
  );
  cpu_mul_div #(.XLEN(8)) dut8 (
    .clk(clk), .rst(rst), .kill(kill), .inValid(iv8), .inReady(ir8), .MDOpe(op8),
    .MDIn1(a8), .MDIn2(b8), .outValid(ov8), .outReady(or8), .MDOut(r8),
    .divZeroFlag(dzf8), .overflowFlag(ovf8)
  );
  task automatic chk(string name, u64 act, u64 exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_md(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b,
                                         output logic dz, output logic ov);
    u64 mask, ua, ub, r;
    longint sa, sb, mn;
    mask = (u64'(1) << w) - 1;
    ua = u64'(a) & mask;
    ub = u64'(b) & mask;
    sa = ((ua >> (w - 1)) & 1) != 0 ? longint'(ua) - longint'(u64'(1) << w) : longint'(ua);
    sb = ((ub >> (w - 1)) & 1) != 0 ? longint'(ub) - longint'(u64'(1) << w) : longint'(ub);
    mn = -(longint'(1) << (w - 1));
    dz = 0;
    ov = 0;
    r = 0;
    if (!op[2]) begin
      case (op)
        MD_MUL:    r = u64'(sa * sb);
        MD_MULH:   r = u64'(sa * sb) >> w;
        MD_MULHSU: r = u64'(sa * longint'(ub)) >> w;
        default:   r = (ua * ub) >> w;
      endcase
    end else if (ub == 0) begin
      dz = 1;
      r = op[1] ? ua : mask;
    end else if (!op[0] && sa == mn && sb == -1) begin
      ov = 1;
      r = op[1] ? 0 : ua;
    end else begin
      case (op)
        MD_DIV:  r = u64'(sa / sb);
        MD_DIVU: r = ua / ub;
        MD_REM:  r = u64'(sa % sb);
        default: r = ua % ub;
      endcase
    end
    return 32'(r & mask);
  endfunction
  task automatic issue(int w, logic [2:0] op, logic [31:0] a, logic [31:0] b, bit hold,
                       output logic [31:0] res, output logic dz, output logic ov, output int lat);
    @(negedge clk);
    if (w == 32) begin iv32 = 1; op32 = op; a32 = a; b32 = b; end
    else begin iv8 = 1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    @(posedge clk);
    #1;
    iv32 = 0;
    iv8 = 0;
    lat = 1;
    while (!(w == 32 ? ov32 : ov8) && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = (w == 32) ? r32 : {24'h0, r8};
    dz = (w == 32) ? dzf32 : dzf8;
    ov = (w == 32) ? ovf32 : ovf8;
    chk("inReady_low_with_outValid", (w == 32) ? ir32 : ir8, 0);
    if (!hold) begin
      if (w == 32) or32 = 1; else or8 = 1;
      @(posedge clk);
      #1;
      or32 = 0;
      or8 = 0;
    end
  endtask
  vec_t vt[$];
  initial begin
    logic [31:0] res, exp, a, b, mn, ones;
    logic dz, ov, edz, eov;
    logic [2:0] op;
    int lat, seen;
    vt.push_back('{MD_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 0, 33});
    vt.push_back('{MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 33});
    vt.push_back('{MD_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 33});
    vt.push_back('{MD_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 0, 0, 33});
    vt.push_back('{MD_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 0, 33});
    vt.push_back('{MD_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 0, 0, 33});
    vt.push_back('{MD_DIVU,   32'd100,      32'd7,        32'd14,       0, 0, 33});
    vt.push_back('{MD_REMU,   32'd100,      32'd7,        32'd2,        0, 0, 33});
    vt.push_back('{MD_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, 1});
    vt.push_back('{MD_REM,    32'd5,        32'd0,        32'd5,        1, 0, 1});
    vt.push_back('{MD_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1, 0, 1});
    vt.push_back('{MD_REMU,   32'd5,        32'd0,        32'd5,        1, 0, 1});
    vt.push_back('{MD_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 1, 1});
    vt.push_back('{MD_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 1, 1});
    vt.push_back('{MD_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        0, 0, 33});
    vt.push_back('{MD_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0, 33});
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("reset_MDOut", r32, 0);
    chk("reset_outValid", ov32, 0);
    chk("reset_inReady", ir32, 1);
    chk("reset_flags", {dzf32, ovf32}, 0);
    chk("reset8_MDOut", r8, 0);
    chk("reset8_inReady", ir8, 1);
    foreach (vt[i]) begin
      issue(32, vt[i].op, vt[i].a, vt[i].b, 0, res, dz, ov, lat);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp);
      chk($sformatf("vec%0d_flags", i), {dz, ov}, {vt[i].dz, vt[i].ov});
      chk($sformatf("vec%0d_latency", i), lat, vt[i].lat);
    end
    issue(32, MD_DIVU, 32'd100, 32'd7, 1, res, dz, ov, lat);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("backpressure_hold", {ov32, ir32, r32}, {1'b1, 1'b0, 32'd14});
    end
    or32 = 1;
    @(posedge clk);
    #1;
    or32 = 0;
    chk("backpressure_release", {ov32, ir32}, 2'b01);
    @(negedge clk);
    iv32 = 1; op32 = MD_DIV; a32 = 32'd1000; b32 = 32'd3;
    @(posedge clk);
    #1;
    iv32 = 0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    kill = 1;
    @(posedge clk);
    #1;
    kill = 0;
    chk("kill_to_idle", {ov32, ir32}, 2'b01);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ov32) seen = 1; end
    chk("kill_no_outValid", seen, 0);
    @(negedge clk);
    kill = 1; iv32 = 1; op32 = MD_DIV; a32 = 32'd5; b32 = 32'd0;
    @(posedge clk);
    #1;
    kill = 0;
    iv32 = 0;
    chk("kill_blocks_accept_inReady", ir32, 1);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ov32) seen = 1; end
    chk("kill_blocks_accept_outValid", seen, 0);
    issue(32, MD_DIV, 32'd5, 32'd0, 0, res, dz, ov, lat);
    chk("pre_reset_dz", dz, 1);
    @(negedge clk);
    iv32 = 1; op32 = MD_MUL; a32 = 32'd7; b32 = 32'd3;
    @(posedge clk);
    #1;
    iv32 = 0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("midbusy_reset_outputs", {r32, ov32, ir32, dzf32, ovf32}, {32'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    for (int pass = 0; pass < 2; pass++) begin
      automatic int w = pass ? 8 : 32;
      mn = 32'h1 << (w - 1);
      ones = (w == 32) ? 32'hFFFFFFFF : ((32'h1 << w) - 1);
      for (int k = 0; k < 150; k++) begin
        op = 3'($urandom_range(0, 7));
        a = $urandom & ones;
        b = $urandom & ones;
        case ($urandom_range(0, 9))
          0: b = 0;
          1: begin a = mn; b = ones; end
          2: b = $urandom_range(1, 5);
          default: ;
        endcase
        exp = ref_md(w, op, a, b, edz, eov);
        issue(w, op, a, b, 0, res, dz, ov, lat);
        chk($sformatf("rnd%0d_%0d_op%0d_%0h_%0h_result", w, k, op, a, b), res, exp);
        chk($sformatf("rnd%0d_%0d_flags", w, k), {dz, ov}, {edz, eov});
        chk($sformatf("rnd%0d_%0d_latency", w, k), lat, (edz | eov) ? 1 : w + 1);
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
